scoreboard_warp: RTL and testbench
==================================

# scoreboard_warp

Per-warp 4-entry scoreboard paired with `IBuffer_warp`. It records in-flight instructions that write a register or access memory, and flags RAW/WAW hazards and memory-ordering hazards on the instruction at the IBuffer read pointer. It returns an entry ID (ScbID) at grant time. Entries are released on writeback, or on replay completion for stores; `Empty` gates warp exit.

## Interface
- Parameters: none; 4 entries and a 2-bit ScbID are fixed.
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-low
- Src1_IB_Scb, Src2_IB_Scb, Dst_IB_Scb  in  5 each  register IDs of the instruction at the IBuffer RP
- Src1_Valid_IB_Scb, Src2_Valid_IB_Scb, Dst_Valid_IB_Scb  in  1 each  qualifiers for the register IDs
- Replayable_IB_Scb  in  1  RP instruction is LW/SW
- RP_Grt_IB_Scb  in  1  RP instruction granted; allocate an entry
- Replay_Complete_IB_Scb  in  1  replay of the IRP instruction finished (all threads served)
- Replay_Complete_ScbID_IB_Scb  in  2  entry that completed
- Replay_Complete_SW_LWbar_IB_Scb  in  1  1 = store, 0 = load
- Clear_Valid_WB_Scb  in  1  writeback occurred for an entry
- Clear_ScbID_WB_Scb  in  2  entry written back
- Full_Scb_IB  out  1  all 4 entries valid
- Empty_Scb_IB  out  1  no entry valid
- Dependent_Scb_IB  out  1  hazard on the RP instruction
- ScbID_Scb_IB  out  2  entry to be allocated on grant
- Pending_Cnt_Scb  out  3  number of valid entries (0–4)

## Operation
- Per-entry state: V (valid), DstV, Dst[4:0], Mem (replayable), Cmp (complete), IsSW.
- Allocation happens at the posedge when RP_Grt=1 and (Dst_Valid | Replayable) and !Full.
  - Target entry = lowest-index entry with V=0; this index drives ScbID_Scb_IB combinationally.
  - Written values: V=1, DstV=Dst_Valid, Dst=Dst_IB, Mem=Replayable, Cmp=!Replayable, IsSW=0.
- A grant with neither Dst_Valid nor Replayable allocates nothing; ScbID_Scb_IB is don't-care.
- A grant while Full is ignored (protocol violation; IBuffer never does this).
- Replay complete acts only on an entry with V=1, Mem=1, Cmp=0; otherwise it is ignored. IBuffer may hold Replay_Complete high on stale entries.
  - SW_LWbar=1: the entry is freed (V=0).
  - SW_LWbar=0: Cmp is set to 1.
- WB clear acts only on an entry with V=1 and Cmp=1, and frees it. A WB clear for an entry with Cmp=0 is an intermediate LW pass and is ignored.
- Dependent = OR over valid entries of the following terms:
  - (Src1_Valid & DstV & Src1==Dst), or the same term for Src2;
  - (Dst_Valid & DstV & Dst_IB==Dst);
  - (Replayable & Mem & Cmp=0).
- No register-0 exemption.
- Full, Empty, Dependent, ScbID and Pending_Cnt are combinational from registered state only. They are evaluated against pre-edge state, with no same-cycle bypass of frees.

## Timing
- Reset values: all V=0, so Full=0, Empty=1, Dependent=0, ScbID=0, Pending_Cnt=0.
- Latency:
  - An allocated entry is visible in Full/Empty/Dependent the cycle after the grant.
  - A free is visible the cycle after the clear event.
- Simultaneous events in one cycle:
  - Allocate plus free of a different entry: both apply.
  - Allocate plus free of the same index cannot occur, because the allocation target is always a V=0 entry.
  - Replay complete (LW) plus WB clear on the same entry: the WB clear is evaluated against pre-edge Cmp=0 and is ignored; the entry ends with Cmp=1 and V=1.
  - Replay complete (SW) plus WB clear on the same entry: the entry is freed.
- Allocation is independent of replay and WB events on other entries; all three may happen in one cycle.
- Reset mid-operation: all entries are invalidated asynchronously, and outputs return to their reset values immediately.

## Test plan
- Reset, then no stimulus -> Empty=1, Full=0, ScbID=0, Pending_Cnt=0.
- Grant ADD R5 (Dst_Valid) -> next cycle ScbID=1, Pending_Cnt=1. Present Src1=5 valid -> Dependent=1. WB clear ID0 -> Dependent=0 next cycle, Empty=1.
- Four grants with Dst R1..R4 -> Full=1 and Pending_Cnt=4. Clear ID2 -> Full=0 and ScbID=2 next cycle. Grant again -> entry 2 reused.
- LW R7 grant (Replayable), WB clear ID0 while Cmp=0 -> entry remains, Dependent=1 for Src1=7. Replay complete LW ID0 together with WB clear -> entry still valid. Later WB clear ID0 -> freed.
- SW grant (Replayable, no Dst), then present another Replayable -> Dependent=1. Replay complete SW ID0 -> Empty=1 next cycle and Dependent=0.
- Replay_Complete asserted on a V=0 ID, then on a non-Mem entry -> no state change. Assert rst mid-sequence with 3 entries valid -> Empty=1 immediately.

Source files
------------

// File: rtl/scoreboard_warp.sv
// Per-warp 4-entry scoreboard paired with IBuffer_warp.
// Tracks in-flight register writers and memory ops. It flags RAW/WAW and
// memory-ordering hazards for the instruction at the IBuffer read pointer,
// and hands out the entry ID that a grant will allocate.
module scoreboard_warp (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] Src1_IB_Scb,
    input  logic [4:0] Src2_IB_Scb,
    input  logic [4:0] Dst_IB_Scb,
    input  logic       Src1_Valid_IB_Scb,
    input  logic       Src2_Valid_IB_Scb,
    input  logic       Dst_Valid_IB_Scb,
    input  logic       Replayable_IB_Scb,
    input  logic       RP_Grt_IB_Scb,
    input  logic       Replay_Complete_IB_Scb,
    input  logic [1:0] Replay_Complete_ScbID_IB_Scb,
    input  logic       Replay_Complete_SW_LWbar_IB_Scb,
    input  logic       Clear_Valid_WB_Scb,
    input  logic [1:0] Clear_ScbID_WB_Scb,
    output logic       Full_Scb_IB,
    output logic       Empty_Scb_IB,
    output logic       Dependent_Scb_IB,
    output logic [1:0] ScbID_Scb_IB,
    output logic [2:0] Pending_Cnt_Scb
);

    localparam int unsigned NUM_ENT = 4;
    localparam int unsigned ID_W    = 2;
    localparam int unsigned REG_W   = 5;
    localparam int unsigned CNT_W   = 3;

    // Per-entry state: valid, dst-valid, dst register, memory op, complete.
    logic [NUM_ENT-1:0]            v_q, v_d;
    logic [NUM_ENT-1:0]            dstv_q, dstv_d;
    logic [NUM_ENT-1:0][REG_W-1:0] dst_q, dst_d;
    logic [NUM_ENT-1:0]            mem_q, mem_d;
    logic [NUM_ENT-1:0]            cmp_q, cmp_d;

    logic            full;
    logic            alloc;
    logic [ID_W-1:0] alloc_id;
    logic            rc_hit;
    logic            wb_hit;
    logic            dep;
    logic [CNT_W-1:0] cnt;

    // Lowest-index free entry; this is the ID handed out on the next grant.
    always_comb begin
        logic found;
        found    = 1'b0;
        alloc_id = '0;
        for (int unsigned i = 0; i < NUM_ENT; i++) begin
            if (!v_q[i] && !found) begin
                found    = 1'b1;
                alloc_id = ID_W'(i);
            end
        end
    end

    assign full = &v_q;

    // Qualify incoming events against pre-edge state; stale events are dropped.
    always_comb begin
        alloc  = RP_Grt_IB_Scb && (Dst_Valid_IB_Scb || Replayable_IB_Scb) && !full;
        rc_hit = Replay_Complete_IB_Scb
              && v_q[Replay_Complete_ScbID_IB_Scb]
              && mem_q[Replay_Complete_ScbID_IB_Scb]
              && !cmp_q[Replay_Complete_ScbID_IB_Scb];
        // A WB on an incomplete LW is an intermediate pass and must not free it.
        wb_hit = Clear_Valid_WB_Scb
              && v_q[Clear_ScbID_WB_Scb]
              && cmp_q[Clear_ScbID_WB_Scb];
    end

    // Next-state: apply free/complete events, then allocation into a free slot.
    always_comb begin
        v_d    = v_q;
        dstv_d = dstv_q;
        dst_d  = dst_q;
        mem_d  = mem_q;
        cmp_d  = cmp_q;

        if (wb_hit) begin
            v_d[Clear_ScbID_WB_Scb] = 1'b0;
        end

        if (rc_hit) begin
            if (Replay_Complete_SW_LWbar_IB_Scb) begin
                v_d[Replay_Complete_ScbID_IB_Scb] = 1'b0;
            end else begin
                cmp_d[Replay_Complete_ScbID_IB_Scb] = 1'b1;
            end
        end

        // The allocation target is always a free entry, so it never collides
        // with the entry touched by a replay-complete or WB clear above.
        if (alloc) begin
            v_d[alloc_id]    = 1'b1;
            dstv_d[alloc_id] = Dst_Valid_IB_Scb;
            dst_d[alloc_id]  = Dst_IB_Scb;
            mem_d[alloc_id]  = Replayable_IB_Scb;
            cmp_d[alloc_id]  = !Replayable_IB_Scb;
        end
    end

    // Entry state registers with asynchronous invalidation on reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v_q    <= '0;
            dstv_q <= '0;
            dst_q  <= '0;
            mem_q  <= '0;
            cmp_q  <= '0;
        end else begin
            v_q    <= v_d;
            dstv_q <= dstv_d;
            dst_q  <= dst_d;
            mem_q  <= mem_d;
            cmp_q  <= cmp_d;
        end
    end

    // Hazard check of the RP instruction against every valid entry.
    always_comb begin
        dep = 1'b0;
        for (int unsigned i = 0; i < NUM_ENT; i++) begin
            if (v_q[i]) begin
                if (Src1_Valid_IB_Scb && dstv_q[i] && (Src1_IB_Scb == dst_q[i])) dep = 1'b1;
                if (Src2_Valid_IB_Scb && dstv_q[i] && (Src2_IB_Scb == dst_q[i])) dep = 1'b1;
                if (Dst_Valid_IB_Scb  && dstv_q[i] && (Dst_IB_Scb  == dst_q[i])) dep = 1'b1;
                if (Replayable_IB_Scb && mem_q[i] && !cmp_q[i])                  dep = 1'b1;
            end
        end
    end

    // Occupancy count of valid entries.
    always_comb begin
        cnt = '0;
        for (int unsigned i = 0; i < NUM_ENT; i++) begin
            cnt = cnt + CNT_W'(v_q[i]);
        end
    end

    assign Full_Scb_IB      = full;
    assign Empty_Scb_IB     = ~|v_q;
    assign Dependent_Scb_IB = dep;
    assign ScbID_Scb_IB     = alloc_id;
    assign Pending_Cnt_Scb  = cnt;

endmodule

// File: tb/tb_scoreboard_warp.sv
// Testbench for scoreboard_warp: a directed sequence followed by random
// traffic. Expected outputs come from an entry-list model and are queued
// for a separate monitor that compares them on the falling edge.
module tb_scoreboard_warp;

    logic       clk;
    logic       rst;
    logic [4:0] src1, src2, dst;
    logic       src1_v, src2_v, dst_v, rep, grt;
    logic       rc;
    logic [1:0] rc_id;
    logic       rc_sw;
    logic       wb;
    logic [1:0] wb_id;
    logic       full_o, empty_o, dep_o;
    logic [1:0] id_o;
    logic [2:0] cnt_o;

    scoreboard_warp dut (
        .clk                             (clk),
        .rst                             (rst),
        .Src1_IB_Scb                     (src1),
        .Src2_IB_Scb                     (src2),
        .Dst_IB_Scb                      (dst),
        .Src1_Valid_IB_Scb               (src1_v),
        .Src2_Valid_IB_Scb               (src2_v),
        .Dst_Valid_IB_Scb                (dst_v),
        .Replayable_IB_Scb               (rep),
        .RP_Grt_IB_Scb                   (grt),
        .Replay_Complete_IB_Scb          (rc),
        .Replay_Complete_ScbID_IB_Scb    (rc_id),
        .Replay_Complete_SW_LWbar_IB_Scb (rc_sw),
        .Clear_Valid_WB_Scb              (wb),
        .Clear_ScbID_WB_Scb              (wb_id),
        .Full_Scb_IB                     (full_o),
        .Empty_Scb_IB                    (empty_o),
        .Dependent_Scb_IB                (dep_o),
        .ScbID_Scb_IB                    (id_o),
        .Pending_Cnt_Scb                 (cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       rst_n;
        logic       grt;
        logic       s1v;
        logic [4:0] s1;
        logic       s2v;
        logic [4:0] s2;
        logic       dv;
        logic [4:0] d;
        logic       rep;
        logic       rc;
        logic [1:0] rcid;
        logic       rcsw;
        logic       wb;
        logic [1:0] wbid;
    } stim_t;

    typedef struct packed {
        logic       full;
        logic       empty;
        logic       dep;
        logic [1:0] id;
        logic [2:0] cnt;
    } exp_t;

    // Model entry: what an in-flight instruction looks like to the scoreboard.
    typedef struct packed {
        logic       busy;
        logic       writes;
        logic [4:0] reg_id;
        logic       is_mem;
        logic       done;
    } slot_t;

    slot_t m [4];
    exp_t  expq [$];
    int    n_tests = 0;
    int    n_fail  = 0;
    int    cyc     = 0;

    function automatic stim_t idle();
        stim_t s;
        s = '0;
        s.rst_n = 1'b1;
        return s;
    endfunction

    function automatic int occupancy();
        int n = 0;
        for (int i = 0; i < 4; i++) if (m[i].busy) n++;
        return n;
    endfunction

    function automatic int first_free();
        for (int i = 0; i < 4; i++) if (!m[i].busy) return i;
        return 0;
    endfunction

    function automatic exp_t predict(stim_t s);
        exp_t e;
        int   n;
        n       = occupancy();
        e.cnt   = 3'(n);
        e.full  = (n == 4);
        e.empty = (n == 0);
        e.id    = 2'(first_free());
        e.dep   = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (m[i].busy) begin
                if (m[i].writes && s.s1v && s.s1 == m[i].reg_id) e.dep = 1'b1;
                if (m[i].writes && s.s2v && s.s2 == m[i].reg_id) e.dep = 1'b1;
                if (m[i].writes && s.dv  && s.d  == m[i].reg_id) e.dep = 1'b1;
                if (m[i].is_mem && !m[i].done && s.rep)          e.dep = 1'b1;
            end
        end
        return e;
    endfunction

    // Advance the model across one clock edge; all decisions use pre-edge slots.
    task automatic model_edge(input stim_t s);
        slot_t nx [4];
        int    slot;
        nx = m;
        if (s.wb && m[s.wbid].busy && m[s.wbid].done) nx[s.wbid].busy = 1'b0;
        if (s.rc && m[s.rcid].busy && m[s.rcid].is_mem && !m[s.rcid].done) begin
            if (s.rcsw) nx[s.rcid].busy = 1'b0;
            else        nx[s.rcid].done = 1'b1;
        end
        if (s.grt && (s.dv || s.rep) && occupancy() < 4) begin
            slot = first_free();
            nx[slot].busy   = 1'b1;
            nx[slot].writes = s.dv;
            nx[slot].reg_id = s.d;
            nx[slot].is_mem = s.rep;
            nx[slot].done   = !s.rep;
        end
        m = nx;
    endtask

    // Drive one cycle of inputs just after the rising edge and queue the expectation.
    task automatic step(input stim_t s);
        @(posedge clk);
        #1;
        rst    = s.rst_n;
        grt    = s.grt;
        src1_v = s.s1v;  src1 = s.s1;
        src2_v = s.s2v;  src2 = s.s2;
        dst_v  = s.dv;   dst  = s.d;
        rep    = s.rep;
        rc     = s.rc;   rc_id = s.rcid;  rc_sw = s.rcsw;
        wb     = s.wb;   wb_id = s.wbid;
        if (!s.rst_n) for (int i = 0; i < 4; i++) m[i] = '0;
        expq.push_back(predict(s));
        if (s.rst_n) model_edge(s);
    endtask

    task automatic chk(input string name, input logic [2:0] act, input logic [2:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    // Monitor: compare every queued expectation on the falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            cyc++;
            if (expq.size() > 0) begin
                e = expq.pop_front();
                chk("full",    3'(full_o),  3'(e.full));
                chk("empty",   3'(empty_o), 3'(e.empty));
                chk("dep",     3'(dep_o),   3'(e.dep));
                chk("pending", cnt_o,       e.cnt);
                if (!e.full) chk("scbid", 3'(id_o), 3'(e.id));
            end
        end
    end

    initial begin
        stim_t s;
        rst = 1'b0; grt = 0; src1 = 0; src2 = 0; dst = 0; src1_v = 0; src2_v = 0;
        dst_v = 0; rep = 0; rc = 0; rc_id = 0; rc_sw = 0; wb = 0; wb_id = 0;
        for (int i = 0; i < 4; i++) m[i] = '0;

        // Reset, then idle.
        s = idle(); s.rst_n = 1'b0; step(s); step(s);
        step(idle()); step(idle());

        // ADD R5, RAW on Src1, then WB clear.
        s = idle(); s.grt = 1; s.dv = 1; s.d = 5; step(s);
        s = idle(); s.s1v = 1; s.s1 = 5; step(s);
        s.wb = 1; s.wbid = 0; step(s);
        s = idle(); s.s1v = 1; s.s1 = 5; step(s);

        // Fill with R1..R4, free ID2, reuse it.
        for (int r = 1; r <= 4; r++) begin
            s = idle(); s.grt = 1; s.dv = 1; s.d = 5'(r); step(s);
        end
        s = idle(); s.dv = 1; s.d = 3; step(s);
        s = idle(); s.wb = 1; s.wbid = 2; step(s);
        step(idle());
        s = idle(); s.grt = 1; s.dv = 1; s.d = 9; step(s);
        s = idle(); s.s2v = 1; s.s2 = 9; step(s);
        for (int i = 0; i < 4; i++) begin
            s = idle(); s.wb = 1; s.wbid = 2'(i); step(s);
        end
        step(idle());

        // LW R7: intermediate WB ignored, LW complete + WB same cycle, final WB.
        s = idle(); s.grt = 1; s.dv = 1; s.d = 7; s.rep = 1; step(s);
        s = idle(); s.s1v = 1; s.s1 = 7; s.wb = 1; s.wbid = 0; step(s);
        s = idle(); s.s1v = 1; s.s1 = 7; step(s);
        s = idle(); s.rc = 1; s.rcid = 0; s.wb = 1; s.wbid = 0; step(s);
        s = idle(); s.s1v = 1; s.s1 = 7; s.rep = 1; step(s);
        s = idle(); s.wb = 1; s.wbid = 0; step(s);
        step(idle());

        // SW then memory-ordering hazard, freed by SW replay complete.
        s = idle(); s.grt = 1; s.rep = 1; step(s);
        s = idle(); s.rep = 1; step(s);
        s = idle(); s.rc = 1; s.rcid = 0; s.rcsw = 1; s.rep = 1; step(s);
        s = idle(); s.rep = 1; step(s);

        // Stale replay completes: V=0 entry, then non-memory entry.
        s = idle(); s.rc = 1; s.rcid = 3; s.rcsw = 1; step(s);
        s = idle(); s.grt = 1; s.dv = 1; s.d = 2; step(s);
        s = idle(); s.rc = 1; s.rcid = 0; step(s);
        s = idle(); s.rc = 1; s.rcid = 0; s.rcsw = 1; step(s);
        s = idle(); s.s1v = 1; s.s1 = 2; step(s);

        // Mid-sequence reset with three entries valid.
        s = idle(); s.grt = 1; s.dv = 1; s.d = 11; step(s);
        s = idle(); s.grt = 1; s.rep = 1; step(s);
        s = idle(); s.rep = 1; s.dv = 1; s.d = 11; step(s);
        s.rst_n = 1'b0; step(s);
        step(s);
        step(idle());

        // Random traffic over a small register range to provoke hazards.
        for (int k = 0; k < 3000; k++) begin
            s       = idle();
            s.rst_n = ($urandom_range(0, 299) != 0);
            s.grt   = ($urandom_range(0, 1) == 1);
            s.dv    = ($urandom_range(0, 2) != 0);
            s.rep   = ($urandom_range(0, 2) == 0);
            s.d     = 5'($urandom_range(0, 7));
            s.s1v   = ($urandom_range(0, 1) == 1);
            s.s1    = 5'($urandom_range(0, 7));
            s.s2v   = ($urandom_range(0, 1) == 1);
            s.s2    = 5'($urandom_range(0, 7));
            s.rc    = ($urandom_range(0, 2) == 0);
            s.rcid  = 2'($urandom_range(0, 3));
            s.rcsw  = ($urandom_range(0, 1) == 1);
            s.wb    = ($urandom_range(0, 2) == 0);
            s.wbid  = 2'($urandom_range(0, 3));
            step(s);
        end

        step(idle());
        repeat (3) @(negedge clk);
        n_tests++;
        if (expq.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left, expected 0", expq.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
